// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared FSM states, unit indices and default class-to-unit map for dispatch_ctrl.
package dispatch_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_RETIRE, S_ERR, S_TMO} state_t;
  localparam int UNIT_EU  = 0;
  localparam int UNIT_BIU = 1;
  localparam int UNIT_FCU = 2;
  localparam int CLS_W = 3;
  // Classes 0..5 -> EU, EU, BIU, BIU, unit 3 (absent with 3 units, so illegal), FCU
  localparam logic [23:0] DEF_CLASS_UNIT_MAP = 24'b000_000_010_011_001_001_000_000;
endpackage

// File: rtl/dispatch_ctrl_class_decode.sv
// class_decode: leading-ones opcode class decode and class-to-unit lookup.
module class_decode
  import dispatch_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_MSB = 21,
  parameter int N_CLASSES = 6,
  parameter int N_UNITS = 3,
  parameter logic [23:0] CLASS_UNIT_MAP = DEF_CLASS_UNIT_MAP
) (
  input  logic [IR_W-1:0]  instr,
  output logic [CLS_W-1:0] k,
  output logic [1:0]       u,
  output logic             illegal
);
  logic [3:0] cnt;
  logic       run;
  logic [2:0] u_raw;
  logic       unused_bits;
  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < N_CLASSES; i++) begin
      run = run & instr[OP_MSB-i];
      cnt = cnt + {3'b000, run};
    end
  end
  assign u_raw = 3'(CLASS_UNIT_MAP >> (3 * cnt));
  assign k = cnt[CLS_W-1:0];
  assign u = u_raw[1:0];
  assign illegal = (cnt == 4'(N_CLASSES)) || (u_raw >= 3'(N_UNITS));
  assign unused_bits = ^instr;
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: single-issue instruction dispatch FSM driving N_UNITS functional units.
// Optional watchdog on WAIT enabled by `define DISPATCH_TIMEOUT_EN (adds err_timeout).
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_MSB = 21,
  parameter int N_CLASSES = 6,
  parameter int N_UNITS = 3,
  parameter logic [23:0] CLASS_UNIT_MAP = DEF_CLASS_UNIT_MAP,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [IR_W-1:0]    instr,
  output logic               instr_ready,
  output logic [N_UNITS-1:0] unit_cs,
  output logic [CLS_W-1:0]   unit_sel,
  input  logic [N_UNITS-1:0] unit_done,
`ifdef DISPATCH_TIMEOUT_EN
  output logic               err_timeout,
`endif
  output logic               done,
  output logic               err_illegal,
  output logic               busy
);
  state_t state, nxt;
  logic [IR_W-1:0]  ir;
  logic [CLS_W-1:0] k;
  logic [1:0]       u;
  logic             illegal;
  logic [3:0]       done4;
  logic             cs_on;
  logic             tmo;
  class_decode #(
    .IR_W(IR_W), .OP_MSB(OP_MSB), .N_CLASSES(N_CLASSES),
    .N_UNITS(N_UNITS), .CLASS_UNIT_MAP(CLASS_UNIT_MAP)
  ) u_dec (
    .instr(ir), .k(k), .u(u), .illegal(illegal)
  );
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW0 = $clog2(TIMEOUT_CYC + 1);
  localparam int TW = TW0 < 8 ? 8 : (TW0 > 16 ? 16 : TW0);
  logic [TW-1:0] wcnt;
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wcnt <= '0;
    else wcnt <= wcnt + 1'b1;
  end
  assign tmo = (wcnt == TW'(TIMEOUT_CYC - 1));
  assign err_timeout = (state == S_TMO);
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && instr_valid) ir <= instr;
    end
  end
  assign done4 = 4'(unit_done);
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = instr_valid ? S_DECODE : S_IDLE;
      S_DECODE: nxt = illegal ? S_ERR : S_ISSUE;
      S_ISSUE:  nxt = S_WAIT;
      // A completion in the limit cycle still retires normally
      S_WAIT:   nxt = done4[u] ? S_RETIRE : (tmo ? S_TMO : S_WAIT);
      default:  nxt = S_IDLE;
    endcase
  end
  assign cs_on = (state == S_ISSUE) || (state == S_WAIT);
  assign unit_cs = cs_on ? N_UNITS'(4'b0001 << u) : '0;
  assign unit_sel = cs_on ? k : '0;
  assign instr_ready = (state == S_IDLE) && !rst;
  assign done = (state == S_RETIRE);
  assign err_illegal = (state == S_ERR);
  assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: vector table, hand sequences and randomized transactions for dispatch_ctrl.
module tb_dispatch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [2:0]  unit_cs;
  logic [2:0]  unit_sel;
  logic [2:0]  unit_done;
  logic        done;
  logic        err_illegal;
  logic        busy;
  int n_chk = 0;
  int n_err = 0;
  int umap[6] = '{0, 0, 1, 1, 3, 2};
  always #5 clk = ~clk;
  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .unit_cs(unit_cs), .unit_sel(unit_sel),
    .unit_done(unit_done), .done(done), .err_illegal(err_illegal), .busy(busy)
  );
  typedef struct {
    logic [31:0] w;
    int          done_at;
    bit          noise;
    bit          ill;
    logic [2:0]  cs;
    logic [2:0]  sel;
    int          lat;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input int n);
    logic [31:0] w;
    w = $urandom;
    for (int i = 0; i < 6; i++)
      if (i < n) w[21-i] = 1'b1;
      else if (i == n) w[21-i] = 1'b0;
    return w;
  endfunction
  function automatic int ref_k(input logic [31:0] w);
    int n = 0;
    while (n < 6 && w[21-n]) n++;
    return n;
  endfunction
  task automatic run_txn(input string nm, input logic [31:0] w, input int done_at, input bit noise,
                         input bit ill, input logic [2:0] ecs, input logic [2:0] esel, input int elat);
    int ndone = 0, nerr = 0, tdone = -1, terr = -1, tcs = -1, bad = 0, waitc = 0;
    @(negedge clk);
    while (!instr_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({nm, "_ready_in"}, instr_ready, 1);
    instr_valid = 1'b1;
    instr = w;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      unit_done = (ill || cyc < done_at) ? 3'b000 : ecs;
      if (noise) unit_done = unit_done | (3'($urandom) & ~ecs);
      @(negedge clk);
      if (unit_cs != 0 && tcs < 0) tcs = cyc;
      if (unit_cs != 0 && unit_cs != ecs) bad++;
      if (unit_cs != 0 && unit_sel != esel) bad++;
      if (unit_cs == 0 && unit_sel != 0) bad++;
      if (done) begin
        ndone++;
        if (tdone < 0) tdone = cyc;
      end
      if (err_illegal) begin
        nerr++;
        if (terr < 0) terr = cyc;
      end
      if (instr_ready) break;
      @(posedge clk);
      #1;
    end
    unit_done = 3'b000;
    chk({nm, "_ready_out"}, instr_ready, 1);
    chk({nm, "_cs_sel"}, bad, 0);
    if (ill) begin
      chk({nm, "_err_cnt"}, nerr, 1);
      chk({nm, "_err_cyc"}, terr, 2);
      chk({nm, "_done_cnt"}, ndone, 0);
    end else begin
      chk({nm, "_done_cnt"}, ndone, 1);
      chk({nm, "_done_cyc"}, tdone, elat);
      chk({nm, "_issue_cyc"}, tcs, 2);
      chk({nm, "_err_cnt"}, nerr, 0);
    end
  endtask
  initial begin
    logic [31:0] bl[10];
    int ek[10];
    int got_sel[$];
    int got_cs[$];
    int dn, idx, kk, c, uu;
    logic [2:0] pcs;
    int opts[5] = '{0, 1, 2, 3, 5};
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    unit_done = '0;
    tv[0] = '{32'h0000_0000, 5, 1'b0, 1'b0, 3'b001, 3'd0, 6};
    tv[1] = '{32'h003E_0000, 6, 1'b1, 1'b0, 3'b100, 3'd5, 7};
    tv[2] = '{32'h003F_0000, 1, 1'b1, 1'b1, 3'b000, 3'd0, 0};
    tv[3] = '{32'h003C_1234, 1, 1'b0, 1'b1, 3'b000, 3'd0, 0};
    tv[4] = '{32'h0020_FFFF, 1, 1'b1, 1'b0, 3'b001, 3'd1, 4};
    tv[5] = '{32'h0030_0000, 3, 1'b0, 1'b0, 3'b010, 3'd2, 4};
    tv[6] = '{32'h0038_0000, 4, 1'b1, 1'b0, 3'b010, 3'd3, 5};
    tv[7] = '{32'hFFDF_FFFF, 2, 1'b0, 1'b0, 3'b001, 3'd0, 4};
    tv[8] = '{32'h003F_FFFF, 2, 1'b0, 1'b1, 3'b000, 3'd0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", unit_cs, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);
    chk("post_rst_outs", {unit_cs, unit_sel, done, err_illegal, busy}, 0);
    for (int i = 0; i < 9; i++)
      run_txn($sformatf("vec%0d", i), tv[i].w, tv[i].done_at, tv[i].noise, tv[i].ill,
              tv[i].cs, tv[i].sel, tv[i].lat);
    // Reset in the middle of WAIT, with unit 1 still asserting done afterwards
    @(negedge clk);
    instr_valid = 1'b1;
    instr = 32'h0030_0000;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_cs_before", unit_cs, 3'b010);
    rst = 1'b1;
    unit_done = 3'b010;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {unit_cs, unit_sel, done, err_illegal, busy}, 0);
    chk("midrst_ready", instr_ready, 1);
    @(negedge clk);
    chk("midrst_stale_done", {done, busy}, 0);
    run_txn("after_rst", 32'h0030_0000, 1, 1'b0, 1'b0, 3'b010, 3'd2, 4);
    // Randomized transactions against the class/latency model
    for (int t = 0; t < 40; t++) begin
      kk = ref_k(mk($urandom_range(0, 6)));
      instr = mk(kk);
      kk = ref_k(instr);
      c = $urandom_range(1, 8);
      uu = kk < 6 ? umap[kk] : 7;
      if (kk == 6 || uu >= 3)
        run_txn($sformatf("rnd%0d", t), instr, c, 1'b1, 1'b1, 3'b000, 3'd0, 0);
      else
        run_txn($sformatf("rnd%0d", t), instr, c, 1'b1, 1'b0, 3'(1 << uu), 3'(kk),
                (c > 3 ? c : 3) + 1);
    end
    // Back-to-back with instr_valid held high; unit answers as soon as selected
    for (int i = 0; i < 10; i++) begin
      ek[i] = opts[$urandom_range(0, 4)];
      bl[i] = mk(ek[i]);
    end
    dn = 0;
    idx = 0;
    pcs = '0;
    @(negedge clk);
    for (int t = 0; t < 300 && dn < 10; t++) begin
      if (unit_cs != 0 && pcs == 0) begin
        got_sel.push_back(int'(unit_sel));
        got_cs.push_back(int'(unit_cs));
      end
      pcs = unit_cs;
      if (done) dn++;
      unit_done = unit_cs;
      instr_valid = idx < 10;
      instr = idx < 10 ? bl[idx] : '0;
      if (instr_ready && idx < 10) idx++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    unit_done = '0;
    chk("b2b_done_cnt", dn, 10);
    chk("b2b_issue_cnt", got_sel.size(), 10);
    for (int i = 0; i < 10 && i < got_sel.size(); i++) begin
      chk($sformatf("b2b_sel%0d", i), got_sel[i], ek[i]);
      chk($sformatf("b2b_cs%0d", i), got_cs[i], 1 << umap[ek[i]]);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
